// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer,
// synchronous flush, control bubbling on empty and a saturating bubble counter.
module pipe_stage_buf #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  assign out_valid  = (state_q != ST_EMPTY);
  assign in_ready   = (state_q != ST_TWO);
  assign out_data   = main_data_q;
  assign out_ctrl   = main_ctrl_q;
  assign bubble_cnt = bubble_q;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_d     = ST_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ST_ONE: begin
          if (in_valid && out_ready) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_valid) begin
            state_d     = ST_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    // An empty stage must never present live write enables downstream.
    if (state_d == ST_EMPTY) begin
      main_ctrl_d = '0;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      bubble_q    <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      bubble_q    <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (CNT_W = 3 to reach saturation).
module tb_pipe_stage_buf;

  localparam int DATA_W = 69;
  localparam int CTRL_W = 10;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int i);
    in_valid = 1'b1;
    in_data  = DATA_W'(32'h10 + i);
    in_ctrl  = CTRL_W'(i + 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic check_word(input string tag, input int i);
    check({tag, ".valid"}, 80'(out_valid), 80'(1));
    check({tag, ".data"},  80'(out_data),  80'(32'h10 + i));
    check({tag, ".ctrl"},  80'(out_ctrl),  80'(i + 1));
  endtask

  initial begin
    // Reset state and in-order streaming at full throughput
    do_reset();
    check("rst.out_valid", 80'(out_valid), 80'(0));
    check("rst.in_ready",  80'(in_ready),  80'(1));
    check("rst.out_data",  80'(out_data),  80'(0));
    check("rst.out_ctrl",  80'(out_ctrl),  80'(0));
    check("rst.bubble",    80'(bubble_cnt), 80'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(i);
      check($sformatf("stream.in_ready%0d", i), 80'(in_ready), 80'(1));
      step();
      check_word($sformatf("stream.D%0d", i), i);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("stream.bubble", 80'(bubble_cnt), 80'(1));

    // Back-pressure: skid absorbs one word, FIFO order preserved
    do_reset();
    out_ready = 1'b1;
    offer(0); step();
    check_word("bp.D0a", 0);
    out_ready = 1'b0;
    offer(1);
    check("bp.in_ready_pre", 80'(in_ready), 80'(1));
    step();
    check_word("bp.D0b", 0);
    check("bp.in_ready_stall1", 80'(in_ready), 80'(0));
    offer(2);
    step();
    check_word("bp.D0c", 0);
    check("bp.in_ready_stall2", 80'(in_ready), 80'(0));
    step();
    check_word("bp.D0d", 0);
    check("bp.in_ready_stall3", 80'(in_ready), 80'(0));
    out_ready = 1'b1;
    step();
    check_word("bp.D1", 1);
    check("bp.in_ready_rise", 80'(in_ready), 80'(1));
    step();
    check_word("bp.D2", 2);
    offer(3); step();
    check_word("bp.D3", 3);
    in_valid = 1'b0; step();
    check("bp.drain_valid", 80'(out_valid), 80'(0));
    check("bp.drain_ctrl",  80'(out_ctrl),  80'(0));
    check("bp.drain_data",  80'(out_data),  80'(32'h13));

    // Flush while full: both held words and the offered 0xAA are dropped
    do_reset();
    offer(0); step();
    offer(1); step();
    check("fl.full_in_ready", 80'(in_ready), 80'(0));
    flush = 1'b1; in_valid = 1'b1; in_data = DATA_W'(8'hAA); in_ctrl = '1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl.out_valid", 80'(out_valid), 80'(0));
    check("fl.out_ctrl",  80'(out_ctrl),  80'(0));
    check("fl.in_ready",  80'(in_ready),  80'(1));
    check("fl.out_data",  80'(out_data),  80'(32'h10));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("fl.after%0d.valid", k), 80'(out_valid), 80'(0));
      check($sformatf("fl.after%0d.data", k),  80'(out_data),  80'(32'h10));
    end

    // Bubble counter saturation
    do_reset();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("sat.bubble10", 80'(bubble_cnt), 80'(7));
    step();
    check("sat.bubble11", 80'(bubble_cnt), 80'(7));

    // Flush does not clear the counter
    flush = 1'b1; step(); flush = 1'b0;
    check("sat.flush_keep", 80'(bubble_cnt), 80'(7));

    // Asynchronous reset while full, asserted between edges
    do_reset();
    offer(4); step();
    offer(5); step();
    in_valid = 1'b0;
    check("ar.pre_in_ready", 80'(in_ready), 80'(0));
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("ar.out_valid", 80'(out_valid),  80'(0));
    check("ar.out_ctrl",  80'(out_ctrl),   80'(0));
    check("ar.out_data",  80'(out_data),   80'(0));
    check("ar.in_ready",  80'(in_ready),   80'(1));
    check("ar.bubble",    80'(bubble_cnt), 80'(0));
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    check("ar.after_valid", 80'(out_valid), 80'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a valid/ready handshake, a two-entry skid buffer, a synchronous flush and control-field bubbling. It supersedes the fixed-field stage registers between ID/EX, EX/MEM and MEM/WB: each stage packs its datapath fields into `in_data` and its write-enable-type control bits into `in_ctrl`. It also absorbs one cycle of downstream back-pressure without a combinational ready path. A saturating counter records the bubbles delivered downstream, for CPI measurement.

## Interface
- `DATA_W`, default 69: payload width, for example alu_result 32 + read_data2 32 + regdst 5.
- `CTRL_W`, default 10: control width, for example regwrite, memwrite, memread, memtoreg and a 6-bit ALU op.
- `CNT_W`, default 16: bubble counter width.

Ports:
- `clk`, input, 1: the only clock; rising edge.
- `reset`, input, 1: asynchronous, active-high.
- `in_valid`, input, 1: upstream holds a valid stage word.
- `in_ready`, output, 1: the buffer can accept a word this cycle.
- `in_data`, input, DATA_W: upstream payload.
- `in_ctrl`, input, CTRL_W: upstream control bits.
- `flush`, input, 1: synchronous kill of all held and incoming words.
- `out_valid`, output, 1: `out_data`/`out_ctrl` hold a valid word.
- `out_ready`, input, 1: downstream consumes the word this cycle.
- `out_data`, output, DATA_W: payload to the next stage.
- `out_ctrl`, output, CTRL_W: control to the next stage; zero whenever `out_valid` = 0.
- `bubble_cnt`, output, CNT_W: count of cycles with `out_ready` = 1 and `out_valid` = 0.

## Operation
- Storage: a main register (drives the outputs) and a skid register. Three states:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - TWO: both valid.
- A transfer occurs on input when `in_valid` and `in_ready` are high, and on output when `out_valid` and `out_ready` are high.
- `in_ready` = 1 in EMPTY and ONE, 0 in TWO. It is a pure function of the registered state.
- Transitions when `flush` = 0:
  - EMPTY: `in_valid` → ONE, main ← in.
  - ONE, `in_valid` and `out_ready` → ONE, main ← in.
  - ONE, `in_valid` and not `out_ready` → TWO, skid ← in, main held.
  - ONE, not `in_valid` and `out_ready` → EMPTY.
  - ONE, otherwise: hold.
  - TWO, `out_ready` → ONE, main ← skid.
  - TWO, otherwise: hold; `in_valid` is ignored because `in_ready` = 0.
- Flush has the highest priority of the non-reset events:
  - Next state EMPTY.
  - Any word offered on the input that cycle is discarded.
  - Any output transfer that cycle still counts as consumed downstream.
- Bubbling:
  - `out_ctrl` is registered to all-zero whenever the next state is EMPTY.
  - A bubble therefore never asserts regwrite or memwrite.
  - `out_data` retains its last value when empty.
- Order is strictly FIFO. No word is duplicated or dropped except by flush.
- `bubble_cnt` increments by 1 on each cycle with `out_ready` = 1 and `out_valid` = 0, and saturates at 2^CNT_W − 1. Flush does not clear it.

## Timing
- Reset, asynchronous: state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_data` = 0, `out_ctrl` = 0, skid = 0, `bubble_cnt` = 0. All outputs settle without a clock edge.
- Latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N.
- Throughput is 1 word per cycle with `out_ready` held high.
- `in_ready` falls in the cycle after a stall fills the skid. It rises in the cycle after the skid drains.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset asserted mid-transfer aborts immediately. Both held words are lost.
- Flush and reset may coincide; reset wins.

## Test plan
- Reset then stream: assert `reset`, release it, then drive words D0..D7 (data = 0x10+i, ctrl = i+1) with `out_ready` = 1. Expected: one word out per cycle, one cycle later, in order; `in_ready` constantly 1; `bubble_cnt` = 1 (the single empty cycle seen while the first word is in flight).
- Back-pressure: stream D0..D3 and drop `out_ready` for 3 cycles after D0 appears. Expected: D0 held; D1 accepted into the skid; `in_ready` = 0 during the stall; on release the output sequence is D0, D1, D2, D3 with no loss or duplication.
- Flush in TWO: fill both entries, then pulse `flush` with `in_valid` = 1 carrying 0xAA. Expected: next cycle `out_valid` = 0, `out_ctrl` = 0, `in_ready` = 1; 0xAA never appears on the output.
- Bubble counter saturation: with CNT_W = 3, `in_valid` = 0 and `out_ready` = 1 for 10 cycles. Expected: `bubble_cnt` = 7 and holding.
- Asynchronous reset mid-stall: in TWO, assert `reset` between clock edges. Expected: immediately `out_valid` = 0, `out_ctrl` = 0, `out_data` = 0, `in_ready` = 1, `bubble_cnt` = 0.
